controller_hub: RTL and testbench
=================================

# controller_hub

Parametrised successor to the two-pad serial controller interface. It reads up to `NUM_CONTROLLERS` shift-register pads (NES/SNES style) of `BUTTONS` bits each. On top of plain polling it adds:
- sticky per-button "pressed" edge flags,
- a one-deep pending-fetch queue,
- an overrun indication.

The hub sits beside the GPU in the top level. The GPU's vblank fetch request triggers it, and the top-level data mux exposes its outputs to the CPU.

## Interface
Parameters:
- `NUM_CONTROLLERS`, 2, number of serial pads (1..8)
- `BUTTONS`, 8, bits per pad (8 or 16)
- `LATCH_TICKS`, 1, ticks `controller_latch` stays high (1..4)

Ports:
- `cpu_clk` input, 1: sole clock; one clock, all state on rising edge
- `rst` input, 1: synchronous, active-high reset
- `controller_clk_in_enable` input, 1: protocol pacing tick (one `cpu_clk` cycle wide)
- `controller_start_fetch` input, 1: fetch request pulse
- `clear_pressed` input, `NUM_CONTROLLERS`: bit i clears pad i pressed flags
- `controller_data_in_B` input, `NUM_CONTROLLERS`: serial data, active-low
- `controller_clk_out_enable` output, 1: pad shift-clock enable
- `controller_latch` output, 1: pad parallel-load strobe
- `buttons_out` output, `NUM_CONTROLLERS*BUTTONS`: held buttons, pad i at `[i*BUTTONS +: BUTTONS]`
- `pressed_out` output, `NUM_CONTROLLERS*BUTTONS`: sticky 0→1 edge flags, same packing
- `fetch_busy` output, 1: state ≠ IDLE
- `fetch_done` output, 1: one-cycle pulse when held buttons update
- `fetch_overrun` output, 1: one-cycle pulse when a request is dropped

## Operation
State machine states:
- **IDLE**: `controller_start_fetch` → LATCH, latch-tick counter cleared.
- **LATCH**: `controller_latch`=1. Count `controller_clk_in_enable` ticks. After `LATCH_TICKS` ticks → SHIFT, bit counter = 0.
- **SHIFT**: `controller_latch`=0. On each tick, every channel samples `~controller_data_in_B[i]` into its shift register, shifting left with the new bit at LSB (first serial bit ends at MSB), and the bit counter increments. After `BUTTONS` ticks → COMMIT.
- **COMMIT** (exactly one `cpu_clk` cycle, tick-independent):
  - shift registers → `buttons_out`;
  - `pressed |= new & ~old`;
  - `fetch_done`=1;
  - → LATCH if pending, else IDLE; pending cleared.

`controller_clk_out_enable` is combinational: SHIFT && `controller_clk_in_enable`, so it coincides with every sample tick.

Request queueing:
- A start while not IDLE sets `pending` (depth 1).
- A start while `pending` is already set is dropped and pulses `fetch_overrun` the next cycle.
- A start in the COMMIT cycle is treated as non-IDLE, so it goes through pending.

Pressed-flag clear:
- `clear_pressed[i]` clears all of pad i's `pressed` bits.
- If a set and a clear of the same bit happen in the same COMMIT cycle, the set wins.

Ticks in IDLE are ignored. Counters are `$clog2(max+1)` wide; no wrap occurs in range.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, `pending` 0, shift registers 0.
- A reset during a fetch aborts it with no `fetch_done`, and held/pressed are zeroed.
- Start latency: the start cycle registers; `controller_latch`=1 from the next cycle.
- Fetch length: `LATCH_TICKS + BUTTONS` ticks plus 1 cycle. `buttons_out` / `pressed_out` change on the same edge on which `fetch_done` rises.
- Back-to-back fetches: with pending set, `controller_latch` rises on the cycle after COMMIT.
- Registered outputs: all except `controller_clk_out_enable`.

## Structure
- Package `controller_hub_pkg`:
  - state enum (IDLE, LATCH, SHIFT, COMMIT);
  - `MAX_BUTTONS`=16 and `MAX_LATCH_TICKS`=4 bounds;
  - a counter-width function.
- Sub-module `controller_channel_m` (param `BUTTONS`), one per pad via generate. It holds that pad's shift register, held register and pressed register, with inputs `sample_en`, `commit`, `clear`, `data_in_B`.
- The top of the block holds only the FSM, counters and the pending/overrun logic.

## Test plan
- **Basic read**: N=2, B=8. Pad 1 serially drives active-low 0x5A (`data_in_B` bits inverted, MSB first), pad 2 drives 0xFF-low (all buttons pressed). Expect `buttons_out`=16'hFF5A and `fetch_done` pulse after 1+8 ticks+1 cycle.
- **Pressed edges**: fetch 0x00 then 0x81. Expect `pressed_out[7:0]`=0x81. Fetch 0x80 → still 0x81. Pulse `clear_pressed`=2'b01 → 0x00.
- **Set/clear collision**: `clear_pressed[0]` asserted in the COMMIT cycle where bit 3 rises. Expect bit 3 remaining 1.
- **Queue/overrun**: start at IDLE, then starts at SHIFT tick 2 and tick 5. Expect one `fetch_overrun` pulse, then a second fetch beginning the cycle after the first `fetch_done`, with 2 `fetch_done` pulses total.
- **Reset mid-fetch**: `rst` during SHIFT tick 4. Expect all outputs 0 the next cycle, no `fetch_done`, and a later start producing a normal 9-tick fetch.
- **Generality**: N=4, B=16, `LATCH_TICKS`=3. Expect `controller_latch` high for exactly 3 ticks, 16 `controller_clk_out_enable` pulses, and a correct 64-bit packed `buttons_out`.

Source files
------------

// File: rtl/controller_hub_pkg.sv
// ============================================================================
// Module      : controller_hub_pkg
// Description : Shared FSM state encoding, bounds and counter sizing helper
//               for the serial controller hub.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package controller_hub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LATCH  = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_COMMIT = 2'd3
    } state_e;

    localparam int MAX_BUTTONS     = 16;
    localparam int MAX_LATCH_TICKS = 4;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/controller_hub_channel.sv
// ============================================================================
// Module      : controller_channel_m
// Description : One pad channel: serial shift register, held buttons and
//               sticky pressed-edge flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module controller_channel_m
    import controller_hub_pkg::*;
#(
    parameter int BUTTONS = 8
) (
    input  logic               cpu_clk,
    input  logic               rst,
    input  logic               sample_en,
    input  logic               commit,
    input  logic               clear,
    input  logic               data_in_B,
    output logic [BUTTONS-1:0] held_o,
    output logic [BUTTONS-1:0] pressed_o
);

    logic [BUTTONS-1:0] shift_q,   shift_d;
    logic [BUTTONS-1:0] held_q,    held_d;
    logic [BUTTONS-1:0] pressed_q, pressed_d;

    always_comb begin
        shift_d   = shift_q;
        held_d    = held_q;
        pressed_d = pressed_q;
        if (sample_en) begin
            shift_d = {shift_q[BUTTONS-2:0], ~data_in_B};
        end
        if (clear) begin
            pressed_d = '0;
        end
        // Applied after the clear so a rising edge in the same cycle survives.
        if (commit) begin
            held_d    = shift_q;
            pressed_d = pressed_d | (shift_q & ~held_q);
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            shift_q   <= '0;
            held_q    <= '0;
            pressed_q <= '0;
        end else begin
            shift_q   <= shift_d;
            held_q    <= held_d;
            pressed_q <= pressed_d;
        end
    end

    assign held_o    = held_q;
    assign pressed_o = pressed_q;

endmodule

`default_nettype wire

// File: rtl/controller_hub.sv
// ============================================================================
// Module      : controller_hub
// Description : Multi-pad serial controller reader with one-deep fetch queue,
//               overrun pulse and per-pad sticky pressed flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module controller_hub
    import controller_hub_pkg::*;
#(
    parameter int NUM_CONTROLLERS = 2,
    parameter int BUTTONS         = 8,
    parameter int LATCH_TICKS     = 1
) (
    input  logic                               cpu_clk,
    input  logic                               rst,
    input  logic                               controller_clk_in_enable,
    input  logic                               controller_start_fetch,
    input  logic [NUM_CONTROLLERS-1:0]         clear_pressed,
    input  logic [NUM_CONTROLLERS-1:0]         controller_data_in_B,
    output logic                               controller_clk_out_enable,
    output logic                               controller_latch,
    output logic [NUM_CONTROLLERS*BUTTONS-1:0] buttons_out,
    output logic [NUM_CONTROLLERS*BUTTONS-1:0] pressed_out,
    output logic                               fetch_busy,
    output logic                               fetch_done,
    output logic                               fetch_overrun
);

    localparam int               LAT_W    = cnt_width(MAX_LATCH_TICKS);
    localparam int               BIT_W    = cnt_width(MAX_BUTTONS);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_TICKS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BUTTONS - 1);

    state_e           state_q,   state_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             latch_q, busy_q, done_q;
    logic             sample_en, commit;

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        bit_cnt_d = bit_cnt_q;
        pending_d = pending_q;
        overrun_d = 1'b0;
        sample_en = 1'b0;
        commit    = 1'b0;

        // COMMIT counts as busy, so a start there is routed through pending.
        if (state_q != ST_IDLE && controller_start_fetch) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (controller_start_fetch) begin
                    state_d   = ST_LATCH;
                    lat_cnt_d = '0;
                end
            end
            ST_LATCH: begin
                if (controller_clk_in_enable) begin
                    if (lat_cnt_q == LAT_LAST) begin
                        state_d   = ST_SHIFT;
                        bit_cnt_d = '0;
                    end else begin
                        lat_cnt_d = lat_cnt_q + LAT_W'(1);
                    end
                end
            end
            ST_SHIFT: begin
                if (controller_clk_in_enable) begin
                    sample_en = 1'b1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                commit    = 1'b1;
                state_d   = pending_d ? ST_LATCH : ST_IDLE;
                lat_cnt_d = '0;
                pending_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lat_cnt_q <= '0;
            bit_cnt_q <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            latch_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            latch_q   <= (state_d == ST_LATCH);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= commit;
        end
    end

    for (genvar gi = 0; gi < NUM_CONTROLLERS; gi++) begin : g_channel
        controller_channel_m #(
            .BUTTONS (BUTTONS)
        ) u_channel (
            .cpu_clk   (cpu_clk),
            .rst       (rst),
            .sample_en (sample_en),
            .commit    (commit),
            .clear     (clear_pressed[gi]),
            .data_in_B (controller_data_in_B[gi]),
            .held_o    (buttons_out[gi*BUTTONS +: BUTTONS]),
            .pressed_o (pressed_out[gi*BUTTONS +: BUTTONS])
        );
    end

    assign controller_clk_out_enable = (state_q == ST_SHIFT) && controller_clk_in_enable;
    assign controller_latch          = latch_q;
    assign fetch_busy                = busy_q;
    assign fetch_done                = done_q;
    assign fetch_overrun             = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_controller_hub.sv
// ============================================================================
// Module      : tb_controller_hub
// Description : Directed scoreboard bench for controller_hub (2x8 and 4x16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controller_hub;

    logic        cpu_clk = 1'b0;
    logic        rst, tick, start_a, start_b;
    logic [1:0]  clear_a, din_a;
    logic [3:0]  clear_b, din_b;
    logic        clkout_a, latch_a, busy_a, done_a, ovr_a;
    logic [15:0] btn_a, prs_a;
    logic        clkout_b, latch_b, busy_b, done_b, ovr_b;
    logic [63:0] btn_b, prs_b;

    int n_pass = 0, n_total = 0, n_done_a = 0, n_ovr_a = 0;

    always #5 cpu_clk = ~cpu_clk;

    controller_hub #(.NUM_CONTROLLERS(2), .BUTTONS(8), .LATCH_TICKS(1)) u_dut_a (
        .cpu_clk(cpu_clk), .rst(rst), .controller_clk_in_enable(tick),
        .controller_start_fetch(start_a), .clear_pressed(clear_a),
        .controller_data_in_B(din_a), .controller_clk_out_enable(clkout_a),
        .controller_latch(latch_a), .buttons_out(btn_a), .pressed_out(prs_a),
        .fetch_busy(busy_a), .fetch_done(done_a), .fetch_overrun(ovr_a)
    );

    controller_hub #(.NUM_CONTROLLERS(4), .BUTTONS(16), .LATCH_TICKS(3)) u_dut_b (
        .cpu_clk(cpu_clk), .rst(rst), .controller_clk_in_enable(tick),
        .controller_start_fetch(start_b), .clear_pressed(clear_b),
        .controller_data_in_B(din_b), .controller_clk_out_enable(clkout_b),
        .controller_latch(latch_b), .buttons_out(btn_b), .pressed_out(prs_b),
        .fetch_busy(busy_b), .fetch_done(done_b), .fetch_overrun(ovr_b)
    );

    // Pad models: latch rewinds to the first (MSB) bit, each shift clock advances.
    logic [7:0]  pat_a [2];
    logic [15:0] pat_b [4];
    int idx_a = 0, idx_b = 0;

    always @(posedge cpu_clk) begin
        if (latch_a) idx_a <= 0; else if (clkout_a) idx_a <= idx_a + 1;
        if (latch_b) idx_b <= 0; else if (clkout_b) idx_b <= idx_b + 1;
    end

    always_comb begin
        for (int i = 0; i < 2; i++) din_a[i] = (idx_a < 8)  ? ~pat_a[i][7 - idx_a]  : 1'b1;
        for (int i = 0; i < 4; i++) din_b[i] = (idx_b < 16) ? ~pat_b[i][15 - idx_b] : 1'b1;
    end

    initial begin
        int tcnt;
        tick = 1'b0;
        tcnt = 0;
        forever begin
            @(posedge cpu_clk);
            #1;
            tick = (tcnt == 3);
            tcnt = (tcnt + 1) % 4;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Scoreboard of {held, pressed} expected at each fetch_done of DUT A.
    logic [15:0] m_held, m_prs;
    logic [31:0] sb [$];

    task automatic push_exp(input logic [1:0] clr_in_commit);
        logic [15:0] nw, cm;
        nw     = {pat_a[1], pat_a[0]};
        cm     = {{8{clr_in_commit[1]}}, {8{clr_in_commit[0]}}};
        m_prs  = (m_prs & ~cm) | (nw & ~m_held);
        m_held = nw;
        sb.push_back({m_held, m_prs});
    endtask

    initial begin
        logic [31:0] e;
        forever begin
            @(negedge cpu_clk);
            if (done_a) begin
                n_done_a++;
                chk("done_has_expectation", (sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_buttons", btn_a, e[31:16]);
                    chk("sb_pressed", prs_a, e[15:0]);
                end
            end
            if (ovr_a) n_ovr_a++;
        end
    end

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge cpu_clk);
        start_a = 1'b0;
    endtask

    task automatic run_fetch_a(input string tag, input logic [1:0] clr_commit);
        int  lt, ce, g;
        bit  got;
        lt = 0; ce = 0; g = 99; got = 0;
        push_exp(clr_commit);
        pulse_start_a();
        chk({tag, "_latch_rise"}, {busy_a, latch_a}, 2'b11);
        for (int c = 0; c < 300 && !got; c++) begin
            if (latch_a && tick) lt++;
            if (clkout_a) begin ce++; g = 0; end else g++;
            clear_a = (g == 1 && ce == 8) ? clr_commit : 2'b00;
            if (done_a) got = 1;
            else @(negedge cpu_clk);
        end
        clear_a = 2'b00;
        chk({tag, "_done_seen"}, got, 1);
        chk({tag, "_latch_ticks"}, lt, 1);
        chk({tag, "_shift_ticks"}, ce, 8);
        chk({tag, "_commit_gap"}, g, 2);
        @(negedge cpu_clk);
        chk({tag, "_done_one_cycle"}, done_a, 0);
    endtask

    task automatic pulse_clear_a(input string tag, input logic [1:0] m);
        clear_a = m;
        @(negedge cpu_clk);
        clear_a = 2'b00;
        m_prs = m_prs & ~{{8{m[1]}}, {8{m[0]}}};
        chk(tag, prs_a, m_prs);
    endtask

    initial begin
        int ce, nd, nov, lt;
        bit got;
        rst = 1'b1; start_a = 0; start_b = 0; clear_a = 0; clear_b = 0;
        pat_a[0] = 8'h00; pat_a[1] = 8'h00;
        for (int i = 0; i < 4; i++) pat_b[i] = 16'h0000;
        m_held = '0; m_prs = '0;
        repeat (3) @(negedge cpu_clk);
        rst = 1'b0;
        @(negedge cpu_clk);
        chk("reset_a_data", {btn_a, prs_a}, 0);
        chk("reset_a_ctl", {latch_a, busy_a, done_a, ovr_a, clkout_a}, 0);
        chk("reset_b_data", {btn_b, prs_b}, 0);

        // Basic read: pad0 0x5A, pad1 all pressed
        pat_a[0] = 8'h5A; pat_a[1] = 8'hFF;
        run_fetch_a("basic", 2'b00);
        chk("basic_buttons", btn_a, 16'hFF5A);

        // Pressed edges
        pulse_clear_a("clear_all", 2'b11);
        pat_a[0] = 8'h00; run_fetch_a("edge0", 2'b00);
        pat_a[0] = 8'h81; run_fetch_a("edge1", 2'b00);
        chk("pressed_81", prs_a[7:0], 8'h81);
        pat_a[0] = 8'h80; run_fetch_a("edge2", 2'b00);
        chk("pressed_sticky", prs_a[7:0], 8'h81);
        pulse_clear_a("clear_pad0", 2'b01);

        // Set/clear collision in COMMIT: bit 3 rises while pad0 is cleared
        pat_a[0] = 8'h88; run_fetch_a("collide", 2'b01);
        chk("collide_bit3", prs_a[7:0], 8'h08);

        // Queue / overrun
        pat_a[0] = 8'h3C;
        push_exp(2'b00); push_exp(2'b00);
        pulse_start_a();
        ce = 0; nd = 0; nov = 0;
        for (int c = 0; c < 600 && nd < 2; c++) begin
            if (clkout_a) ce++;
            if (done_a) begin
                nd++;
                if (nd == 1) chk("b2b_latch_after_commit", latch_a, 1);
            end
            if (ovr_a) nov++;
            start_a = clkout_a && (ce == 2 || ce == 5);
            if (nd < 2) @(negedge cpu_clk);
        end
        start_a = 1'b0;
        chk("queue_dones", nd, 2);
        chk("queue_overruns", nov, 1);
        chk("queue_shift_ticks", ce, 16);
        @(negedge cpu_clk);

        // Reset mid-fetch at SHIFT tick 4
        pulse_start_a();
        ce = 0;
        for (int c = 0; c < 300 && ce < 4; c++) begin
            if (clkout_a) ce++;
            if (ce < 4) @(negedge cpu_clk);
        end
        chk("rst_reach_tick4", ce, 4);
        rst = 1'b1;
        @(negedge cpu_clk);
        rst = 1'b0;
        m_held = '0; m_prs = '0;
        chk("midrst_data", {btn_a, prs_a}, 0);
        chk("midrst_ctl", {latch_a, busy_a, done_a, ovr_a, clkout_a}, 0);
        repeat (60) @(negedge cpu_clk);
        run_fetch_a("post_rst", 2'b00);
        chk("post_rst_buttons", btn_a, 16'hFF3C);

        // Generality: 4 pads x 16 buttons, 3 latch ticks
        pat_b[0] = 16'h1234; pat_b[1] = 16'hABCD; pat_b[2] = 16'h8001; pat_b[3] = 16'hFFFF;
        start_b = 1'b1;
        @(negedge cpu_clk);
        start_b = 1'b0;
        lt = 0; ce = 0; got = 0;
        for (int c = 0; c < 800 && !got; c++) begin
            if (latch_b && tick) lt++;
            if (clkout_b) ce++;
            if (done_b) got = 1;
            else @(negedge cpu_clk);
        end
        chk("gen_done_seen", got, 1);
        chk("gen_latch_ticks", lt, 3);
        chk("gen_shift_ticks", ce, 16);
        chk("gen_buttons", btn_b, 64'hFFFF_8001_ABCD_1234);
        chk("gen_pressed", prs_b, 64'hFFFF_8001_ABCD_1234);

        repeat (4) @(negedge cpu_clk);
        chk("sb_drained", sb.size(), 0);
        chk("done_total", n_done_a, 8);
        chk("overrun_total", n_ovr_a, 1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
